muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle multiply/divide engine that produces the 64-bit (2×WIDTH) hi/lo result consumed by the hilo register and the hilo forwarding path. It is the parametrised successor to the single-cycle ALU hilo path. It runs MULT/MULTU/DIV/DIVU over several cycles, exposes busy/done so hazard logic can stall, and accepts a cancel from pipeline flush. It sits in the Execute stage beside the ALU; hilores feeds the E/M pipeline register.

Parameters:
WIDTH, 32, operand width; hilores is 2*WIDTH.
MUL_CYCLES, 3, multiply latency in cycles from start to done (must be >= 1).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  request; sampled only when idle
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
cancel  in  1  abort current operation (flush)
srca  in  WIDTH  multiplicand / dividend
srcb  in  WIDTH  multiplier / divisor
busy  out  1  operation in progress; hazard unit stalls on it
done  out  1  one-cycle pulse, hilores valid
hilores  out  2*WIDTH  {hi,lo}: mult = {product high, product low}; div = {remainder, quotient}
div_by_zero  out  1  valid with done; 1 if a DIV/DIVU had srcb==0

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset; the reset port is named reset.
- Reset, synchronous, dominates everything, including mid-operation: state->IDLE; busy=0, done=0, hilores=0, div_by_zero=0, counters=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: start & ~cancel -> latch op and operands.
  - Mult ops go to MUL with count=MUL_CYCLES-1.
  - Div ops go to DIV with count=WIDTH; div operands are stored as magnitudes when op=DIV.
- MUL: full product is computed from latched operands: signed for MULT, unsigned for MULTU.
  - count decrements each cycle; at count==0 -> DONE.
  - For MUL_CYCLES==1, the path goes IDLE -> DONE directly.
- DIV: restoring radix-2, one quotient bit per cycle, WIDTH iterations.
  - When count hits 0 -> FIX.
- FIX: apply signs for DIV: quotient negated if the operand signs differ; remainder takes the sign of the dividend. Then -> DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE. hilores and div_by_zero are updated on entry to DONE.
- Output persistence: hilores and div_by_zero hold until the next DONE entry.
- busy=1 in MUL, DIV, FIX; busy=0 in IDLE and DONE. busy is registered.
- Latency (start in cycle 0):
  - done in cycle MUL_CYCLES for mult ops.
  - done in cycle WIDTH+2 for div ops (iterations in cycles 1..WIDTH, FIX in WIDTH+1).
- start while busy or in DONE: ignored, not queued.
- cancel in MUL/DIV/FIX: -> IDLE next cycle; no done pulse; hilores and div_by_zero keep their prior values.
- start and cancel in the same IDLE cycle: cancel wins, nothing starts.
- cancel in DONE: done still pulses, since the result is already committed.
- Divide by zero:
  - lo = all ones, hi = srca (original signed value), div_by_zero=1.
  - Still takes full div latency.
- Signed overflow (-2^(WIDTH-1) / -1): lo = -2^(WIDTH-1), hi = 0; no flag.
- Arithmetic:
  - Magnitude uses WIDTH+1-bit internal values so that -2^(WIDTH-1) converts correctly.
  - Product width is 2*WIDTH, with no truncation.

Decomposition:
- Shared package muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state enum (IDLE, MUL, DIV, FIX, DONE).
- One sub-module, div_core: the iterative restoring divider. It takes load, dividend/divisor magnitudes and step enable, and returns quotient and remainder magnitudes.
- Sign handling, multiply, FSM and output registers stay in muldiv_unit.

Test Plan:
- WIDTH=32, MUL_CYCLES=3:
  - MULT srca=0xFFFFFFFF, srcb=5 -> done exactly 3 cycles after start, hilores=0xFFFFFFFF_FFFFFFFB.
  - The same operands with MULTU -> hilores=0x00000004_FFFFFFFB.
  - busy=1 in cycles 1-2 and 0 when done.
- DIV srca=-7 (0xFFFFFFF9), srcb=2 -> done at cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU srca=100, srcb=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 with done.
  - A following MULTU 2×3 -> div_by_zero=0, hilores=0x00000000_00000006.
- Start DIVU 50/7, assert cancel in cycle 10 -> busy=0 in cycle 11, no done ever pulses, hilores unchanged from the prior result.
  - start pulses while busy in cycles 2-9 have no effect.
  - start with cancel in the same IDLE cycle -> busy stays 0.
- reset asserted in cycle 5 of a DIV -> busy=0, done=0, hilores=0 in the next cycle.
  - A new MULT 3×4 then completes normally with hilores=0xC.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide engine.
// Op encodings and FSM state enum.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Iterative restoring divider on unsigned magnitudes.
// One quotient bit per step; WIDTH steps per division.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Shift in the next dividend bit and try a subtraction.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        ge      = shifted >= {1'b0, dvs_q};
        diff    = shifted[WIDTH-1:0] - dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            rem_d = ge ? diff : shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ge};
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine for the hilo path.
// Produces {hi,lo}; busy stalls the pipe, cancel aborts on flush.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic               cancel,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] hilores,
    output logic               div_by_zero
);

    localparam int CMAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] hilo_q, hilo_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               in_sgn;
    logic               div_load;
    logic               div_step;
    logic [WIDTH-1:0]   quo_mag;
    logic [WIDTH-1:0]   rem_mag;
    logic               sgn_div;
    logic               q_neg;
    logic               r_neg;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               b_zero;
    logic [2*WIDTH-1:0] div_res;

    // Full 2W product; sign-extending then truncating is exact.
    function automatic logic [2*WIDTH-1:0] mul_full(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             sgn
    );
        logic [2*WIDTH-1:0] xe;
        logic [2*WIDTH-1:0] ye;
        xe = {{WIDTH{sgn & x[WIDTH-1]}}, x};
        ye = {{WIDTH{sgn & y[WIDTH-1]}}, y};
        return xe * ye;
    endfunction

    // W+1 bit negate so the most negative value maps to 2^(W-1).
    function automatic logic [WIDTH-1:0] mag(
        input logic [WIDTH-1:0] x,
        input logic             sgn
    );
        logic [WIDTH:0] xe;
        xe = {sgn & x[WIDTH-1], x};
        if (xe[WIDTH]) begin
            xe = -xe;
        end
        return xe[WIDTH-1:0];
    endfunction

    assign in_sgn   = ~op[0];
    assign div_load = (state_q == IDLE) & start & ~cancel & op[1];
    assign div_step = (state_q == DIV);

    div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend (mag(srca, in_sgn)),
        .divisor  (mag(srcb, in_sgn)),
        .quotient (quo_mag),
        .remainder(rem_mag)
    );

    // Sign fix-up and divide-by-zero result selection.
    always_comb begin
        sgn_div = (op_q == OP_DIV);
        q_neg   = sgn_div & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        r_neg   = sgn_div & a_q[WIDTH-1];
        q_fix   = q_neg ? -quo_mag : quo_mag;
        r_fix   = r_neg ? -rem_mag : rem_mag;
        b_zero  = (b_q == '0);
        div_res = b_zero ? {a_q, {WIDTH{1'b1}}} : {r_fix, q_fix};
    end

    // Next-state, counter and result capture.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        hilo_d  = hilo_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    op_d = op_e'(op);
                    a_d  = srca;
                    b_d  = srcb;
                    if (op[1]) begin
                        state_d = DIV;
                        cnt_d   = CW'(WIDTH);
                    end else if (MUL_CYCLES == 1) begin
                        state_d = DONE;
                        hilo_d  = mul_full(srca, srcb, in_sgn);
                        dbz_d   = 1'b0;
                    end else begin
                        state_d = MUL;
                        cnt_d   = CW'(MUL_CYCLES - 1);
                    end
                end
            end
            MUL: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = DONE;
                    hilo_d  = mul_full(a_q, b_q, op_q == OP_MULT);
                    dbz_d   = 1'b0;
                end
            end
            DIV: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                hilo_d  = div_res;
                dbz_d   = b_zero;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (cancel && (state_q inside {MUL, DIV, FIX})) begin
            state_d = IDLE;
            cnt_d   = '0;
            hilo_d  = hilo_q;
            dbz_d   = dbz_q;
        end
        busy_d = state_d inside {MUL, DIV, FIX};
        done_d = (state_d == DONE);
    end

    // State and registered outputs; reset wins mid-operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            hilo_q  <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            hilo_q  <= hilo_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hilores     = hilo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32, MUL_CYCLES=3).
// Cycle 0 is the cycle in which start is driven.
module tb_muldiv_unit;

    localparam logic [1:0] T_MULT  = 2'b00;
    localparam logic [1:0] T_MULTU = 2'b01;
    localparam logic [1:0] T_DIV   = 2'b10;
    localparam logic [1:0] T_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        cancel;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic        done;
    logic [63:0] hilores;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(
        .WIDTH(32),
        .MUL_CYCLES(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .cancel     (cancel),
        .srca       (srca),
        .srcb       (srcb),
        .busy       (busy),
        .done       (done),
        .hilores    (hilores),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(
        input logic [1:0]  o,
        input logic [31:0] a,
        input logic [31:0] b
    );
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy: got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL rst_done: got %b want 0", done);
        end
        checks++;
        if (hilores !== 64'h0) begin
            errors++;
            $display("FAIL rst_hilo: got %h want 0", hilores);
        end
        checks++;
        if (div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL rst_dbz: got %b want 0", div_by_zero);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_mult();
        int cyc;
        start_op(T_MULT, 32'hFFFF_FFFF, 32'd5);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL mul_c1: busy=%b done=%b want 1 0", busy, done);
        end
        step();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL mul_c2: busy=%b done=%b want 1 0", busy, done);
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_c3: done=%b busy=%b want 1 0", done, busy);
        end
        checks++;
        if (hilores !== 64'hFFFF_FFFF_FFFF_FFFB) begin
            errors++;
            $display("FAIL mult_res: got %h want fffffffffffffffb", hilores);
        end
        // start during DONE must be dropped
        start = 1'b1;
        op    = T_MULTU;
        srca  = 32'd7;
        srcb  = 32'd7;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_start: done=%b busy=%b want 0 0", done, busy);
        end
        step();
        start_op(T_MULTU, 32'hFFFF_FFFF, 32'd5);
        wait_done(cyc);
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL multu_lat: got %0d want 3", cyc);
        end
        checks++;
        if (hilores !== 64'h0000_0004_FFFF_FFFB) begin
            errors++;
            $display("FAIL multu_res: got %h want 00000004fffffffb", hilores);
        end
        step();
    endtask

    task automatic test_div();
        logic [1:0]  vo [5];
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [63:0] vr [5];
        logic        vz [5];
        int cyc;
        vo[0] = T_DIV;  va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;
        vr[0] = 64'hFFFF_FFFF_FFFF_FFFD; vz[0] = 1'b0;
        vo[1] = T_DIV;  va[1] = 32'h8000_0000; vb[1] = 32'hFFFF_FFFF;
        vr[1] = 64'h0000_0000_8000_0000; vz[1] = 1'b0;
        vo[2] = T_DIV;  va[2] = 32'd20; vb[2] = 32'hFFFF_FFFD;
        vr[2] = 64'h0000_0002_FFFF_FFFA; vz[2] = 1'b0;
        vo[3] = T_DIVU; va[3] = 32'hFFFF_FFFF; vb[3] = 32'h10;
        vr[3] = 64'h0000_000F_0FFF_FFFF; vz[3] = 1'b0;
        vo[4] = T_DIV;  va[4] = 32'hFFFF_FFF9; vb[4] = 32'd0;
        vr[4] = 64'hFFFF_FFF9_FFFF_FFFF; vz[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start_op(vo[i], va[i], vb[i]);
            wait_done(cyc);
            checks++;
            if (cyc !== 34) begin
                errors++;
                $display("FAIL div%0d_lat: got %0d want 34", i, cyc);
            end
            checks++;
            if (hilores !== vr[i]) begin
                errors++;
                $display("FAIL div%0d_res: got %h want %h", i, hilores, vr[i]);
            end
            checks++;
            if (div_by_zero !== vz[i]) begin
                errors++;
                $display("FAIL div%0d_dbz: got %b want %b", i, div_by_zero, vz[i]);
            end
            step();
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        start_op(T_DIVU, 32'd100, 32'd0);
        wait_done(cyc);
        checks++;
        if (cyc !== 34) begin
            errors++;
            $display("FAIL dz_lat: got %0d want 34", cyc);
        end
        checks++;
        if (hilores !== 64'h0000_0064_FFFF_FFFF) begin
            errors++;
            $display("FAIL dz_res: got %h want 00000064ffffffff", hilores);
        end
        checks++;
        if (div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dz_flag: got %b want 1", div_by_zero);
        end
        step();
        start_op(T_MULTU, 32'd2, 32'd3);
        wait_done(cyc);
        checks++;
        if (hilores !== 64'h6 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL dz_clear: got %h/%b want 6/0", hilores, div_by_zero);
        end
        step();
    endtask

    task automatic test_cancel();
        logic seen;
        start_op(T_DIVU, 32'd50, 32'd7);
        step();
        for (int c = 2; c < 10; c++) begin
            start = 1'b1;
            op    = T_MULT;
            srca  = 32'd1;
            srcb  = 32'd1;
            step();
        end
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL can_c10: busy=%b want 1", busy);
        end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL can_c11: busy=%b want 0", busy);
        end
        seen = 1'b0;
        repeat (40) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL can_quiet: activity=%b want 0", seen);
        end
        checks++;
        if (hilores !== 64'h6 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL can_hold: got %h/%b want 6/0", hilores, div_by_zero);
        end
        start  = 1'b1;
        cancel = 1'b1;
        op     = T_MULTU;
        srca   = 32'd9;
        srcb   = 32'd9;
        step();
        start  = 1'b0;
        cancel = 1'b0;
        seen   = 1'b0;
        repeat (5) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL sc_same: activity=%b want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_op(T_DIV, 32'd1000, 32'd3);
        repeat (4) step();
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_ctl: busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (hilores !== 64'h0) begin
            errors++;
            $display("FAIL rmid_hilo: got %h want 0", hilores);
        end
        reset = 1'b0;
        step();
        start_op(T_MULT, 32'd3, 32'd4);
        wait_done(cyc);
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL rmid_lat: got %0d want 3", cyc);
        end
        checks++;
        if (hilores !== 64'hC) begin
            errors++;
            $display("FAIL rmid_res: got %h want c", hilores);
        end
        step();
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 2'b00;
        srca   = '0;
        srcb   = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_cancel();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
